// File: rtl/qspi_matmul_pkg.sv
// Shared types and helpers for the QSPI matrix multiplier: FSM states, accumulator sizing,
// result narrowing. Purely combinational definitions; no latency or backpressure of its own.
package qspi_matmul_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT, DONE} state_e;

  function automatic int ACC_W(input int dw, input int dim);
    return 2 * dw + $clog2(dim);
  endfunction

  // Narrow an accumulator sum to ow bits: clamp to all-ones when sat is set, else keep low bits.
  function automatic logic [63:0] sat_trunc(input logic [63:0] sum, input int ow, input logic sat);
    logic [63:0] mask;
    mask = (64'd1 << ow) - 64'd1;
    if (sat && (sum > mask)) return mask;
    return sum & mask;
  endfunction

endpackage

// File: rtl/qspi_matmul_nxn_sync.sv
// Two-flop synchroniser with a third flop for rising-edge detection.
// Level is 2 clk behind the pin, rise pulse is 1 clk wide; no backpressure.
module qspi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/qspi_matmul_nxn.sv
// QSPI-attached DIMxDIM integer matrix multiplier: load A, load B, DIM^3 MAC cycles, shift out C.
// Serial input lags the pin by 3 clk; the host paces everything with qspi_clk, CS high aborts.
module qspi_matmul_nxn
  import qspi_matmul_pkg::*;
#(
  parameter int DIM   = 2,
  parameter int DW    = 8,
  parameter int OW    = 8,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qspi_clk,
  input  logic             qspi_cs_n,
  input  logic [LANES-1:0] qspi_io_in,
  input  logic             sat_en,
  output logic [LANES-1:0] qspi_io_out,
  output logic [LANES-1:0] qspi_io_oe,
  output logic             busy,
  output logic             err
);

  localparam int N      = DIM * DIM;
  localparam int IW     = $clog2(N);
  localparam int AW     = ACC_W(DW, DIM);
  localparam int IN_CH  = DW / LANES;
  localparam int OUT_CH = OW / LANES;
  localparam int CW     = $clog2((IN_CH > OUT_CH) ? IN_CH : OUT_CH) + 1;

  if (DIM < 2 || DIM > 4 || (DW % LANES) != 0 || (OW % LANES) != 0) begin : g_bad_param
    $error("qspi_matmul_nxn: illegal DIM/DW/OW/LANES combination");
  end

  state_e        state_q;
  logic [DW-1:0] a_q [N];
  logic [DW-1:0] b_q [N];
  logic [OW-1:0] c_q [N];
  logic [DW-1:0] sh_q;
  logic [OW-1:0] osh_q;
  logic [AW-1:0] acc_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] ch_q;
  logic [1:0]    i_q, j_q, k_q;
  logic          oe_q, err_q;

  logic qclk_rise, qclk_lvl_unused, cs_lvl, cs_rise_unused;

  qspi_edge_sync #(.RST_VAL(1'b0)) u_qclk_sync (
    .clk_i(clk), .rst_ni(rst_n), .d_i(qspi_clk), .level_o(qclk_lvl_unused), .rise_o(qclk_rise)
  );

  // CS resets to the deasserted level so reset release never looks like a select.
  qspi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i(clk), .rst_ni(rst_n), .d_i(qspi_cs_n), .level_o(cs_lvl), .rise_o(cs_rise_unused)
  );

  logic [DW-1:0] sh_nxt;
  logic [OW-1:0] osh_nxt, conv;
  logic [IW-1:0] a_idx, b_idx, c_idx, idx_inc;
  logic [AW-1:0] acc_d;
  logic          last_k, last_j, last_i, last_idx, in_last, out_last;

  always_comb begin
    sh_nxt   = DW'({sh_q, qspi_io_in});
    osh_nxt  = OW'({osh_q, {LANES{1'b0}}});
    a_idx    = IW'(int'(i_q) * DIM + int'(k_q));
    b_idx    = IW'(int'(k_q) * DIM + int'(j_q));
    c_idx    = IW'(int'(i_q) * DIM + int'(j_q));
    idx_inc  = idx_q + IW'(1);
    acc_d    = ((k_q == 2'd0) ? '0 : acc_q) + AW'(a_q[a_idx]) * AW'(b_q[b_idx]);
    conv     = OW'(sat_trunc(64'(acc_d), OW, sat_en));
    last_k   = (k_q == 2'(DIM - 1));
    last_j   = (j_q == 2'(DIM - 1));
    last_i   = (i_q == 2'(DIM - 1));
    last_idx = (idx_q == IW'(N - 1));
    in_last  = (ch_q == CW'(IN_CH - 1));
    out_last = (ch_q == CW'(OUT_CH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ch_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      sh_q    <= '0;
      osh_q   <= '0;
      acc_q   <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int e = 0; e < N; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else if (state_q != IDLE && state_q != DONE && cs_lvl) begin
      // Abort outranks any edge seen in the same cycle; err and C are left untouched.
      state_q <= IDLE;
      oe_q    <= 1'b0;
      osh_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cs_lvl) begin
            err_q   <= 1'b0;
            idx_q   <= '0;
            ch_q    <= '0;
            state_q <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B: begin
          if (qclk_rise) begin
            sh_q <= sh_nxt;
            ch_q <= in_last ? '0 : ch_q + CW'(1);
            if (in_last) begin
              if (state_q == LOAD_A) a_q[idx_q] <= sh_nxt;
              else                   b_q[idx_q] <= sh_nxt;
              idx_q <= last_idx ? '0 : idx_inc;
              if (last_idx) begin
                state_q <= (state_q == LOAD_A) ? LOAD_B : COMPUTE;
                i_q     <= '0;
                j_q     <= '0;
                k_q     <= '0;
              end
            end
          end
        end
        COMPUTE: begin
          if (qclk_rise) err_q <= 1'b1;
          acc_q <= acc_d;
          k_q   <= last_k ? '0 : k_q + 2'd1;
          if (last_k) begin
            c_q[c_idx] <= conv;
            j_q        <= last_j ? '0 : j_q + 2'd1;
            if (last_j) begin
              i_q <= last_i ? '0 : i_q + 2'd1;
              if (last_i) begin
                // C[0] was finished DIM^2 - 1 dot products ago, so it is safe to present now.
                state_q <= OUTPUT;
                oe_q    <= 1'b1;
                osh_q   <= c_q[0];
                idx_q   <= '0;
                ch_q    <= '0;
              end
            end
          end
        end
        OUTPUT: begin
          if (qclk_rise) begin
            if (out_last) begin
              ch_q  <= '0;
              idx_q <= idx_inc;
              osh_q <= c_q[idx_inc];
              if (last_idx) begin
                state_q <= DONE;
                oe_q    <= 1'b0;
                osh_q   <= '0;
                idx_q   <= '0;
              end
            end else begin
              ch_q  <= ch_q + CW'(1);
              osh_q <= osh_nxt;
            end
          end
        end
        DONE: begin
          if (cs_lvl) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign qspi_io_out = osh_q[OW-1 -: LANES];
  assign qspi_io_oe  = {LANES{oe_q}};
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_qspi_matmul_nxn.sv
// Directed bench: a DIM=2/LANES=4 instance and a DIM=3/LANES=1 instance share one host model;
// sel picks which one the host talks to.
module tb_qspi_matmul_nxn;

  logic       clk = 1'b0;
  logic       rst_n, qclk, cs, sat_en, sel;
  logic [3:0] din;
  int         dim, lanes, n_tests, n_fail, t_oe;

  logic [3:0] out2, oe2;
  logic       busy2, err2;
  logic [0:0] out3, oe3;
  logic       busy3, err3;
  logic       qclk2, qclk3, cs2, cs3;
  logic [3:0] out_m;
  logic       oe_full, busy_m, err_m;

  always #5 clk = ~clk;

  assign qclk2   = qclk & ~sel;
  assign qclk3   = qclk & sel;
  assign cs2     = sel ? 1'b1 : cs;
  assign cs3     = sel ? cs : 1'b1;
  assign out_m   = sel ? {3'b000, out3} : out2;
  assign oe_full = sel ? (oe3 == 1'b1) : (oe2 == 4'hF);
  assign busy_m  = sel ? busy3 : busy2;
  assign err_m   = sel ? err3 : err2;

  qspi_matmul_nxn #(.DIM(2), .DW(8), .OW(8), .LANES(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .qspi_clk(qclk2), .qspi_cs_n(cs2), .qspi_io_in(din),
    .sat_en(sat_en), .qspi_io_out(out2), .qspi_io_oe(oe2), .busy(busy2), .err(err2)
  );

  qspi_matmul_nxn #(.DIM(3), .DW(8), .OW(8), .LANES(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .qspi_clk(qclk3), .qspi_cs_n(cs3), .qspi_io_in(din[0:0]),
    .sat_en(sat_en), .qspi_io_out(out3), .qspi_io_oe(oe3), .busy(busy3), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int hold);
    qclk = 1'b1;
    repeat (hold) @(negedge clk);
    qclk = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  // mode 0: plain edges; 1: hold the final edge high and time it to oe; 2: extra edge in COMPUTE
  task automatic send_elem(input logic [7:0] v, input int mode);
    for (int c = 8 / lanes - 1; c >= 0; c--) begin
      din = (lanes == 4) ? v[c*4 +: 4] : {3'b000, v[c]};
      @(negedge clk);
      if (c == 0 && mode == 1) begin
        qclk = 1'b1;
        t_oe = 0;
        while (!oe_full && t_oe < 200) begin
          @(negedge clk);
          t_oe++;
        end
        qclk = 1'b0;
        repeat (4) @(negedge clk);
      end else if (c == 0 && mode == 2) begin
        pulse(1);
        pulse(1);
      end else begin
        pulse(4);
      end
    end
  endtask

  task automatic start();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run(input logic [71:0] a, input logic [71:0] b, input int mode);
    int n = dim * dim;
    start();
    for (int e = 0; e < n; e++) send_elem(a[8*(n-1-e) +: 8], 0);
    for (int e = 0; e < n; e++) send_elem(b[8*(n-1-e) +: 8], (e == n - 1) ? mode : 0);
  endtask

  task automatic wait_oe();
    int t = 0;
    while (!oe_full && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("oe_wait", {31'd0, oe_full}, 32'd1);
  endtask

  task automatic read_chk(input string tag, input logic [71:0] c);
    int n = dim * dim;
    logic [7:0] val;
    wait_oe();
    for (int e = 0; e < n; e++) begin
      val = 8'h00;
      for (int k = 0; k < 8 / lanes; k++) begin
        val = 8'((val << lanes) | out_m);
        pulse(4);
      end
      chk($sformatf("%s_c%0d", tag, e), {24'd0, val}, {24'd0, c[8*(n-1-e) +: 8]});
    end
    chk({tag, "_oe_done"}, {31'd0, oe_full}, 32'd0);
  endtask

  task automatic end_txn(input string tag);
    repeat (5) @(negedge clk);
    chk({tag, "_busy_held"}, {31'd0, busy_m}, 32'd1);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_busy_idle"}, {31'd0, busy_m}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; t_oe = 0;
    rst_n = 1'b0; cs = 1'b1; qclk = 1'b0; din = 4'h0; sat_en = 1'b0;
    sel = 1'b0; dim = 2; lanes = 4;
    #1;
    chk("rst_out", {28'd0, out2}, 32'd0);
    chk("rst_oe", {28'd0, oe2}, 32'd0);
    chk("rst_busy", {30'd0, busy2, busy3}, 32'd0);
    chk("rst_err", {30'd0, err2, err3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 2x2 basic product, truncating, with oe timing (3 clk sync + 8 MAC cycles)
    run(72'h01020304, 72'h05060708, 1);
    chk("t1_oe_latency", t_oe, 32'd11);
    chk("t1_err", {31'd0, err_m}, 32'd0);
    read_chk("t1", 72'h13162B32);
    end_txn("t1");

    // all-0xFF operands: sum 0x1FC02 per element
    sat_en = 1'b1;
    run(72'hFFFFFFFF, 72'hFFFFFFFF, 0);
    read_chk("sat", 72'hFFFFFFFF);
    end_txn("sat");
    sat_en = 1'b0;
    run(72'hFFFFFFFF, 72'hFFFFFFFF, 0);
    read_chk("trunc", 72'h02020202);
    end_txn("trunc");

    // 3x3 single-lane: identity * {1..9}, oe after 3 + 27 clk
    sel = 1'b1; dim = 3; lanes = 1;
    run(72'h010000000100000001, 72'h010203040506070809, 1);
    chk("d3_oe_latency", t_oe, 32'd30);
    read_chk("d3", 72'h010203040506070809);
    end_txn("d3");

    // abort after 3 of 4 A elements, then a clean transaction
    sel = 1'b0; dim = 2; lanes = 4;
    start();
    for (int e = 0; e < 3; e++) send_elem(8'(e + 1), 0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy", {31'd0, busy_m}, 32'd0);
    chk("abort_oe", {28'd0, oe2}, 32'd0);
    run(72'h01010101, 72'h01020304, 0);
    read_chk("abort2", 72'h04060406);
    end_txn("abort2");

    // stray qspi_clk edge during COMPUTE sets sticky err, result intact
    run(72'h02030405, 72'h01000001, 2);
    wait_oe();
    chk("err_set", {31'd0, err_m}, 32'd1);
    read_chk("err", 72'h02030405);
    end_txn("err");
    chk("err_sticky", {31'd0, err_m}, 32'd1);
    start();
    chk("err_clear", {31'd0, err_m}, 32'd0);

    // finish that load, then reset in the middle of shifting out
    for (int e = 0; e < 4; e++) send_elem(8'(e + 1), 0);
    for (int e = 0; e < 4; e++) send_elem(8'(e + 5), 0);
    wait_oe();
    pulse(4);
    pulse(4);
    chk("mid_out_busy", {31'd0, busy_m}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out", {28'd0, out2}, 32'd0);
    chk("mrst_oe", {28'd0, oe2}, 32'd0);
    chk("mrst_busy", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cs = 1'b1;
    repeat (4) @(negedge clk);
    run(72'h01020304, 72'h05060708, 0);
    read_chk("post_rst", 72'h13162B32);
    end_txn("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
